// File: rtl/deserializer.sv
// Serial-to-parallel word assembler (MSB first) feeding a show-ahead output FIFO.
// Optional error counter output err_cnt_o is enabled by defining DESER_ERR_CNT_EN.
module deserializer #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ser_data_i,
    input  logic             ser_val_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_val_o,
    input  logic             data_rdy_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             ovf_o
`ifdef DESER_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt_o
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [OccW-1:0] FullOcc = OccW'(FIFO_DEPTH);

    logic [CntW-1:0]  r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;
    logic             r_ovf;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [OccW-1:0]  r_occ;

    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_frame_err;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_ovf;

    always_comb begin
        w_word      = (r_shift << 1) | WIDTH'(ser_data_i);
        w_last      = ser_val_i && (r_bit_cnt == LastBit);
        w_frame_err = !ser_val_i && (r_bit_cnt != '0);
        w_full      = (r_occ == FullOcc);
        w_pop       = data_val_o && data_rdy_i;
        // A pop in the same cycle frees the slot, so a full buffer still accepts the word.
        w_push_ok   = w_last && (!w_full || w_pop);
        w_ovf       = w_last && w_full && !w_pop;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_ovf       <= w_ovf;
            if (!ser_val_i) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_last) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CntW'(1);
                r_shift   <= w_word;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok && !rst_i) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_occ <= r_occ + OccW'(1);
                2'b01:   r_occ <= r_occ - OccW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_comb begin
        data_val_o  = (r_occ != '0);
        data_o      = data_val_o ? r_mem[r_rd_ptr] : '0;
        busy_o      = (r_bit_cnt != '0);
        frame_err_o = r_frame_err;
        ovf_o       = r_ovf;
    end

`ifdef DESER_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic [8:0] w_err_sum;

    always_comb begin
        w_err_sum = {1'b0, r_err_cnt} + {8'd0, w_frame_err} + {8'd0, w_ovf};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    // Error counter not built.
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: queue-based reference model compared every cycle,
// plus directed literal checks. Define DESER_ERR_CNT_EN to also exercise err_cnt_o.
module tb_deserializer;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         ser_data_i;
    logic         ser_val_i;
    logic         data_rdy_i;
    logic [W-1:0] data_o;
    logic         data_val_o;
    logic         busy_o;
    logic         frame_err_o;
    logic         ovf_o;
`ifdef DESER_ERR_CNT_EN
    logic [7:0]   err_cnt_o;
`endif

    deserializer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ser_data_i  (ser_data_i),
        .ser_val_i   (ser_val_i),
        .data_o      (data_o),
        .data_val_o  (data_val_o),
        .data_rdy_i  (data_rdy_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .ovf_o       (ovf_o)
`ifdef DESER_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    int           m_nbits;
    int           m_partial;
    logic [W-1:0] m_q[$];
    bit           m_ferr;
    bit           m_ovf;
    int           m_err;

    int           n_tests;
    int           n_fail;
    bit           chk_en;
    logic [W-1:0] got[$];
    int           ferr_seen;
    int           ovf_seen;
    int           val_cycles;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic d, input logic y);
        bit   pop;
        bit   push;
        logic [W-1:0] word;
        if (r) begin
            m_nbits = 0; m_partial = 0; m_q.delete();
            m_ferr = 0; m_ovf = 0; m_err = 0;
            return;
        end
        pop    = (m_q.size() > 0) && y;
        push   = 0;
        word   = '0;
        m_ferr = 0;
        m_ovf  = 0;
        if (v) begin
            m_partial = m_partial * 2 + int'(d);
            m_nbits++;
            if (m_nbits == W) begin
                push = 1; word = W'(m_partial);
                m_nbits = 0; m_partial = 0;
            end
        end else if (m_nbits != 0) begin
            m_ferr = 1; m_nbits = 0; m_partial = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() == D) m_ovf = 1;
            else m_q.push_back(word);
        end
        m_err = m_err + int'(m_ferr) + int'(m_ovf);
        if (m_err > 255) m_err = 255;
    endtask

    task automatic step(input logic r, input logic v, input logic d, input logic y);
        rst_i = r; ser_val_i = v; ser_data_i = d; data_rdy_i = y;
        @(posedge clk);
        model_edge(r, v, d, y);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic y);
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, w[i], y);
    endtask

    task automatic idle(input int n, input logic y);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, y);
    endtask

    task automatic clear_obs();
        got.delete();
        ferr_seen = 0; ovf_seen = 0; val_cycles = 0;
    endtask

    task automatic check_word(input string name, input int idx, input logic [W-1:0] exp);
        logic [31:0] a;
        a = 32'hDEAD;
        if (idx < got.size()) a = 32'(got[idx]);
        cmp(name, a, 32'(exp));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] exp_data;
            exp_data = '0;
            if (m_q.size() > 0) exp_data = m_q[0];
            cmp("model_data_val", 32'(data_val_o), 32'(m_q.size() > 0));
            cmp("model_data", 32'(data_o), 32'(exp_data));
            cmp("model_busy", 32'(busy_o), 32'(m_nbits != 0));
            cmp("model_frame_err", 32'(frame_err_o), 32'(m_ferr));
            cmp("model_ovf", 32'(ovf_o), 32'(m_ovf));
`ifdef DESER_ERR_CNT_EN
            cmp("model_err_cnt", 32'(err_cnt_o), 32'(m_err));
`endif
            if (data_val_o === 1'b1 && data_rdy_i === 1'b1) got.push_back(data_o);
            if (frame_err_o === 1'b1) ferr_seen++;
            if (ovf_o === 1'b1) ovf_seen++;
            if (data_val_o === 1'b1) val_cycles++;
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; chk_en = 0;
        m_nbits = 0; m_partial = 0; m_ferr = 0; m_ovf = 0; m_err = 0;
        rst_i = 1'b1; ser_val_i = 1'b0; ser_data_i = 1'b0; data_rdy_i = 1'b0;
        clear_obs();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1;
        cmp("rst_data_val", 32'(data_val_o), 0);
        cmp("rst_data", 32'(data_o), 0);
        cmp("rst_busy", 32'(busy_o), 0);
        cmp("rst_frame_err", 32'(frame_err_o), 0);
        cmp("rst_ovf", 32'(ovf_o), 0);
        idle(2, 1'b1);

        // Single word 0x2D, one-cycle latency
        clear_obs();
        send_word(6'h2D, 1'b1);
        cmp("w1_lat_val", 32'(data_val_o), 1);
        cmp("w1_lat_data", 32'(data_o), 32'h2D);
        idle(4, 1'b1);
        cmp("w1_count", got.size(), 1);
        check_word("w1_word", 0, 6'h2D);
        cmp("w1_val_cycles", val_cycles, 1);

        // Back-to-back words
        clear_obs();
        send_word(6'h2D, 1'b1);
        send_word(6'h12, 1'b1);
        idle(3, 1'b1);
        cmp("b2b_count", got.size(), 2);
        check_word("b2b_w0", 0, 6'h2D);
        check_word("b2b_w1", 1, 6'h12);
        cmp("b2b_no_ferr", ferr_seen, 0);

        // Truncated frame then a good word
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        cmp("trunc_busy", 32'(busy_o), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("trunc_ferr", 32'(frame_err_o), 1);
        cmp("trunc_busy_fall", 32'(busy_o), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cmp("trunc_ferr_end", 32'(frame_err_o), 0);
        send_word(6'h3F, 1'b1);
        idle(3, 1'b1);
        cmp("trunc_count", got.size(), 1);
        check_word("trunc_word", 0, 6'h3F);
        cmp("trunc_ferr_pulses", ferr_seen, 1);

        // Overflow on fifth word
        clear_obs();
        for (int k = 1; k <= 5; k++) send_word(W'(k), 1'b0);
        cmp("ovf_pulse", 32'(ovf_o), 1);
        cmp("ovf_head", 32'(data_o), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp("ovf_pulse_end", 32'(ovf_o), 0);
        idle(6, 1'b1);
        cmp("ovf_count", got.size(), 4);
        for (int k = 0; k < 4; k++) check_word("ovf_word", k, W'(k + 1));
        cmp("ovf_drained", 32'(data_val_o), 0);
        cmp("ovf_pulses", ovf_seen, 1);

        // Reset mid-word (with other inputs active) discards partial word
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        cmp("rstmid_busy", 32'(busy_o), 0);
        send_word(6'h15, 1'b1);
        idle(3, 1'b1);
        cmp("rstmid_count", got.size(), 1);
        check_word("rstmid_word", 0, 6'h15);
        cmp("rstmid_no_ferr", ferr_seen, 0);

        // Push and pop in the same cycle while full
        clear_obs();
        for (int k = 0; k < 4; k++) send_word(W'(8'h21 + k), 1'b0);
        for (int i = 5; i >= 1; i--) step(1'b0, 1'b1, W'(8'h25) >> i, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        cmp("fullpp_no_ovf", 32'(ovf_o), 0);
        idle(8, 1'b1);
        cmp("fullpp_count", got.size(), 5);
        for (int k = 0; k < 5; k++) check_word("fullpp_word", k, W'(8'h21 + k));
        cmp("fullpp_ovf_pulses", ovf_seen, 0);

        // Reset discards buffered words
        clear_obs();
        send_word(6'h0A, 1'b0);
        send_word(6'h0B, 1'b0);
        cmp("rstbuf_full_val", 32'(data_val_o), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cmp("rstbuf_val", 32'(data_val_o), 0);
        cmp("rstbuf_data", 32'(data_o), 0);
        idle(3, 1'b1);
        cmp("rstbuf_count", got.size(), 0);

`ifdef DESER_ERR_CNT_EN
        // Error counter saturation
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        idle(2, 1'b1);
        cmp("errcnt_sat", 32'(err_cnt_o), 255);
        idle(5, 1'b1);
        cmp("errcnt_hold", 32'(err_cnt_o), 255);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        cmp("errcnt_rst", 32'(err_cnt_o), 0);
`endif

        idle(2, 1'b1);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
